scr1_jtag_host: RTL and testbench

Command-driven JTAG initiator that drives TCK/TMS/TDI and samples TDO toward a TAP controller and its DR/IR shift chains. Used as an on-chip debug master and as the bench-side driver for TAPC verification. Host logic accepts RESET / IR-scan / DR-scan / IDLE commands and returns the TDO bits captured during each scan. The host tracks the target TAP state itself and always parks the TAP in Run-Test/Idle (RTI).

---
 rtl/scr1_jtag_host_pkg.sv | 50 +++++
 rtl/scr1_jtag_host_tck_gen.sv | 36 +++
 rtl/scr1_jtag_host.sv | 222 ++++++++++++++++++++++
 tb/tb_scr1_jtag_host.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_jtag_host_pkg.sv
// Shared types and TMS sequence tables for the JTAG host.
package scr1_jtag_host_pkg;

  typedef enum logic [1:0] {
    CMD_RESET   = 2'd0,
    CMD_IR_SCAN = 2'd1,
    CMD_DR_SCAN = 2'd2,
    CMD_IDLE    = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SHIFT,
    ST_POST,
    ST_RUN,
    ST_RESP
  } state_e;

  localparam int unsigned TMS_PAT_W = 6;
  localparam int unsigned STEP_W    = 3;

  // TMS patterns, bit 0 is driven first
  localparam logic [TMS_PAT_W-1:0] TMS_RESET       = 6'b011111;
  localparam logic [STEP_W-1:0]    TMS_RESET_LEN   = 3'd6;
  localparam logic [TMS_PAT_W-1:0] TMS_DR_HDR      = 6'b000001;
  localparam logic [STEP_W-1:0]    TMS_DR_HDR_LEN  = 3'd3;
  localparam logic [TMS_PAT_W-1:0] TMS_IR_HDR      = 6'b000011;
  localparam logic [STEP_W-1:0]    TMS_IR_HDR_LEN  = 3'd4;
  localparam logic [TMS_PAT_W-1:0] TMS_TRAILER     = 6'b000001;
  localparam logic [STEP_W-1:0]    TMS_TRAILER_LEN = 3'd2;

  // Header pattern for a command; RESET is treated as a header-only command
  function automatic logic [TMS_PAT_W-1:0] hdr_pat(input cmd_type_e t);
    case (t)
      CMD_IR_SCAN: return TMS_IR_HDR;
      CMD_DR_SCAN: return TMS_DR_HDR;
      default:     return TMS_RESET;
    endcase
  endfunction

  function automatic logic [STEP_W-1:0] hdr_len(input cmd_type_e t);
    case (t)
      CMD_IR_SCAN: return TMS_IR_HDR_LEN;
      CMD_DR_SCAN: return TMS_DR_HDR_LEN;
      default:     return TMS_RESET_LEN;
    endcase
  endfunction

endpackage

// File: rtl/scr1_jtag_host_tck_gen.sv
// TCK divider: toggles tck every TCK_DIV clks while enabled, with edge strobes.
module scr1_jtag_host_tck_gen #(
  parameter int unsigned TCK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TCK_DIV - 1);

  logic [CW-1:0] cnt;

  // Phase counter and tck register; parked low whenever disabled
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Fall strobe coincides with the clk edge that drops tck; rise strobe marks
  // the first clk cycle with tck high so the synchronized tdo has settled
  assign fall_c = en && tck && (cnt == CNT_MAX);
  assign rise_c = en && tck && (cnt == '0);

endmodule

// File: rtl/scr1_jtag_host.sv
// Command-driven JTAG initiator; tracks the TAP and always parks it in RTI.
module scr1_jtag_host
  import scr1_jtag_host_pkg::*;
#(
  parameter int unsigned SCR1_MAX_LEN = 64,
  parameter int unsigned SCR1_TCK_DIV = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [1:0]                        cmd_type,
  input  logic [$clog2(SCR1_MAX_LEN+1)-1:0] cmd_len,
  input  logic [SCR1_MAX_LEN-1:0]           cmd_data,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [SCR1_MAX_LEN-1:0]           rsp_data,
  output logic                              tap_sync,
  output logic                              tck,
  output logic                              tms,
  output logic                              tdi,
  input  logic                              tdo
);

  localparam int unsigned LW = $clog2(SCR1_MAX_LEN + 1);
  localparam int unsigned IW = (SCR1_MAX_LEN > 1) ? $clog2(SCR1_MAX_LEN) : 1;

  state_e                  state_q, state_d;
  cmd_type_e               typ_q, typ_d;
  logic [LW-1:0]           len_q, len_d;
  logic [SCR1_MAX_LEN-1:0] data_q, data_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic [LW-1:0]           bit_q, bit_d;
  logic                    tms_d, tdi_d, rsp_valid_d, tap_sync_d, cmd_ready_d;
  logic [SCR1_MAX_LEN-1:0] rsp_data_d;
  logic [TMS_PAT_W-1:0]    cur_pat;
  logic [STEP_W-1:0]       cur_len;
  logic [IW-1:0]           bit_idx;
  logic                    last_bit;
  logic                    tdo_s1, tdo_s2;
  logic                    tck_en, rise_c, fall_c;

  assign tck_en   = (state_q == ST_PRE) || (state_q == ST_SHIFT) ||
                    (state_q == ST_POST) || (state_q == ST_RUN);
  assign bit_idx  = bit_q[IW-1:0];
  assign last_bit = (LW'(bit_q + LW'(1)) == len_q);

  scr1_jtag_host_tck_gen #(
    .TCK_DIV (SCR1_TCK_DIV)
  ) u_tck_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (tck_en),
    .tck    (tck),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  // Two-flop synchronizer for the asynchronous tdo
  always_ff @(posedge clk) begin
    if (rst) begin
      tdo_s1 <= 1'b0;
      tdo_s2 <= 1'b0;
    end else begin
      tdo_s1 <= tdo;
      tdo_s2 <= tdo_s1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      typ_q     <= CMD_RESET;
      len_q     <= '0;
      data_q    <= '0;
      step_q    <= '0;
      bit_q     <= '0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tap_sync  <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      typ_q     <= typ_d;
      len_q     <= len_d;
      data_q    <= data_d;
      step_q    <= step_d;
      bit_q     <= bit_d;
      tms       <= tms_d;
      tdi       <= tdi_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      tap_sync  <= tap_sync_d;
      cmd_ready <= cmd_ready_d;
    end
  end

  // Next-state and output logic; tms/tdi change on fall strobes, counters on rise
  always_comb begin
    state_d     = state_q;
    typ_d       = typ_q;
    len_d       = len_q;
    data_d      = data_q;
    step_d      = step_q;
    bit_d       = bit_q;
    tms_d       = tms;
    tdi_d       = tdi;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    tap_sync_d  = tap_sync;
    cur_pat     = hdr_pat(typ_q);
    cur_len     = hdr_len(typ_q);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          typ_d      = cmd_type_e'(cmd_type);
          len_d      = (cmd_len > LW'(SCR1_MAX_LEN)) ? LW'(SCR1_MAX_LEN) : cmd_len;
          data_d     = cmd_data;
          step_d     = '0;
          bit_d      = '0;
          rsp_data_d = '0;
          case (typ_d)
            CMD_RESET: begin
              state_d = ST_PRE;
              tms_d   = 1'b1;
              tdi_d   = 1'b0;
            end
            CMD_IDLE: begin
              if (len_d != '0) begin
                state_d = ST_RUN;
                tms_d   = 1'b0;
                tdi_d   = 1'b0;
              end
            end
            default: begin
              if (len_d == '0) begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
              end else begin
                // every scan header opens with TMS=1 out of RTI
                state_d = ST_PRE;
                tms_d   = 1'b1;
                tdi_d   = 1'b0;
              end
            end
          endcase
        end
      end

      ST_PRE: begin
        if (rise_c) step_d = step_q + STEP_W'(1);
        if (fall_c) begin
          if (step_q == cur_len) begin
            step_d = '0;
            if (typ_q == CMD_RESET) begin
              state_d    = ST_IDLE;
              tms_d      = 1'b0;
              tap_sync_d = 1'b1;
            end else begin
              state_d = ST_SHIFT;
              tdi_d   = data_q[0];
              tms_d   = (len_q == LW'(1));
            end
          end else begin
            tms_d = cur_pat[step_q];
          end
        end
      end

      ST_SHIFT: begin
        if (rise_c) begin
          rsp_data_d[bit_idx] = tdo_s2;
          bit_d               = bit_q + LW'(1);
        end
        if (fall_c) begin
          if (bit_q == len_q) begin
            state_d = ST_POST;
            tms_d   = TMS_TRAILER[0];
            tdi_d   = 1'b0;
          end else begin
            tdi_d = data_q[bit_idx];
            tms_d = last_bit;
          end
        end
      end

      ST_POST: begin
        if (rise_c) step_d = step_q + STEP_W'(1);
        if (fall_c) begin
          if (step_q == TMS_TRAILER_LEN) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            tms_d       = 1'b0;
          end else begin
            tms_d = TMS_TRAILER[step_q];
          end
        end
      end

      ST_RUN: begin
        if (rise_c) bit_d = bit_q + LW'(1);
        if (fall_c && (bit_q == len_q)) state_d = ST_IDLE;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE) && !rsp_valid_d;
  end

endmodule

// File: tb/tb_scr1_jtag_host.sv
// Bench for scr1_jtag_host: behavioural TAP model plus directed and random scans.
module tb_scr1_jtag_host;

  localparam int unsigned MAX_LEN = 64;
  localparam int unsigned DIV     = 2;
  localparam int unsigned LW      = $clog2(MAX_LEN + 1);

  localparam logic [1:0] T_RESET = 2'd0;
  localparam logic [1:0] T_IR    = 2'd1;
  localparam logic [1:0] T_DR    = 2'd2;
  localparam logic [1:0] T_IDLE  = 2'd3;

  // IEEE 1149.1 TAP states for the target model
  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                 PAUDR = 6, EX2DR = 7, UPDDR = 8, SELIR = 9, CAPIR = 10,
                 SHIR = 11, EX1IR = 12, PAUIR = 13, EX2IR = 14, UPDIR = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_type;
  logic [LW-1:0]     cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  logic              tap_sync;
  logic              tck, tms, tdi;
  logic              tdo = 1'b0;

  always #5 clk = ~clk;

  scr1_jtag_host #(
    .SCR1_MAX_LEN (MAX_LEN),
    .SCR1_TCK_DIV (DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .tap_sync  (tap_sync),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
  );

  // ---------------- target TAP model ----------------
  int          tap = TLR;
  int          rises = 0;
  bit          tms_log[$];
  bit          tdi_log[$];
  logic [63:0] dr_sr = '0, dr_upd = '0;
  logic [4:0]  ir_sr = '0, ir_upd = '0;
  logic [63:0] dr_cap;
  logic [4:0]  ir_cap;

  function automatic int tap_next(input int s, input bit m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDDR : PAUDR;
      PAUDR: return m ? EX2DR : PAUDR;
      EX2DR: return m ? UPDDR : SHDR;
      UPDDR: return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPDIR : PAUIR;
      PAUIR: return m ? EX2IR : PAUIR;
      EX2IR: return m ? UPDIR : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  // TAP acts on rising tck: log pins, run the state's action, advance
  always @(posedge tck) begin
    rises = rises + 1;
    tms_log.push_back(tms);
    tdi_log.push_back(tdi);
    case (tap)
      CAPDR: dr_sr = dr_cap;
      SHDR:  dr_sr = {tdi, dr_sr[63:1]};
      UPDDR: dr_upd = dr_sr;
      CAPIR: ir_sr = ir_cap;
      SHIR:  ir_sr = {tdi, ir_sr[4:1]};
      UPDIR: ir_upd = ir_sr;
      default: ;
    endcase
    tap = tap_next(tap, tms);
  end

  // TAP drives tdo on falling tck
  always @(negedge tck) begin
    tdo = (tap == SHDR) ? dr_sr[0] : (tap == SHIR) ? ir_sr[0] : 1'b0;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected TMS stream from the command rules; returns the TCK count
  function automatic int exp_tms(input logic [1:0] t, input int unsigned len, output logic [127:0] v);
    bit q[$];
    v = '0;
    if (t == T_RESET) begin
      repeat (5) q.push_back(1'b1);
      q.push_back(1'b0);
    end else if (t == T_IDLE) begin
      repeat (len) q.push_back(1'b0);
    end else if (len > 0) begin
      q.push_back(1'b1);
      if (t == T_IR) q.push_back(1'b1);
      q.push_back(1'b0);
      q.push_back(1'b0);
      for (int i = 0; i < int'(len); i++) q.push_back(i == int'(len) - 1);
      q.push_back(1'b1);
      q.push_back(1'b0);
    end
    foreach (q[i]) v[7'(i)] = q[i];
    return q.size();
  endfunction

  // Issue one command and wait (bounded) for completion
  task automatic run_cmd(input logic [1:0] t, input int unsigned len, input logic [63:0] data,
                         output int busy, output int start, output int seen);
    int guard;
    busy = 0; seen = 0; guard = 0;
    while (cmd_ready !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_cmd", 128'(cmd_ready), 128'(1));
    start     = rises;
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_len   = LW'(len);
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    forever begin
      if (t == T_DR || t == T_IR) begin
        if (rsp_valid === 1'b1) break;
      end else if (cmd_ready === 1'b1) break;
      if (rsp_valid === 1'b1) seen++;
      busy++;
      if (busy > 4000) break;
      @(negedge clk);
    end
  endtask

  task automatic simple_cmd(input logic [1:0] t, input int unsigned len);
    int busy, start, seen, n, eff;
    logic [127:0] etms, otms;
    eff = (len > MAX_LEN) ? MAX_LEN : len;
    run_cmd(t, len, 64'd0, busy, start, seen);
    n = exp_tms(t, eff, etms);
    otms = '0;
    for (int i = 0; i < rises - start && i < 128; i++) otms[7'(i)] = tms_log[start + i];
    check("cmd_busy_clks", 128'(busy), 128'(2 * DIV * n));
    check("cmd_tck_count", 128'(rises - start), 128'(n));
    check("cmd_tms_seq", otms, etms);
    check("cmd_no_rsp", 128'(seen), 128'(0));
    check("cmd_tap_rti", 128'(tap), 128'(RTI));
    if (n > 0) check("cmd_pins_park", 128'({tck, tms}), 128'(2'b00));
    if (t == T_RESET) check("cmd_tap_sync", 128'(tap_sync), 128'(1));
  endtask

  task automatic scan(input logic [1:0] t, input int unsigned len, input logic [63:0] data, input int hold);
    int busy, start, seen, n, eff, hdr, bad;
    logic [127:0] etms, otms, otdi, s, m;
    logic [63:0]  exp_rsp;
    eff = (len > MAX_LEN) ? MAX_LEN : len;
    run_cmd(t, len, data, busy, start, seen);
    n = exp_tms(t, eff, etms);
    otms = '0;
    for (int i = 0; i < rises - start && i < 128; i++) otms[7'(i)] = tms_log[start + i];
    check("scan_busy_clks", 128'(busy), 128'(2 * DIV * n));
    check("scan_tck_count", 128'(rises - start), 128'(n));
    check("scan_tms_seq", otms, etms);
    // stream seen by the host: capture value first, then the shifted-in tdi bits
    hdr = (t == T_IR) ? 4 : 3;
    s = (t == T_IR) ? ((128'(data) << 5) | 128'(ir_cap)) : {data, dr_cap};
    m = (128'd1 << eff) - 128'd1;
    exp_rsp = 64'(s & m);
    if (eff > 0) begin
      otdi = '0;
      for (int i = 0; i < eff; i++) otdi[7'(i)] = tdi_log[start + hdr + i];
      check("scan_tdi_bits", otdi, 128'(data) & m);
      if (t == T_IR) check("scan_ir_update", 128'(ir_upd), 128'(5'(s >> eff)));
      else           check("scan_dr_update", 128'(dr_upd), 128'(64'(s >> eff)));
    end
    check("scan_rsp_valid", 128'(rsp_valid), 128'(1));
    check("scan_rsp_data", 128'(rsp_data), 128'(exp_rsp));
    check("scan_tap_rti", 128'(tap), 128'(RTI));
    check("scan_park", 128'({tck, cmd_ready}), 128'(2'b00));
    bad = 0;
    repeat (hold) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== exp_rsp || cmd_ready !== 1'b0 || tck !== 1'b0) bad++;
    end
    if (hold > 0) check("scan_hold_stable", 128'(bad), 128'(0));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("scan_release", 128'({rsp_valid, cmd_ready}), 128'(2'b01));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard, start, n_rnd;
    logic [1:0] t;
    rst = 1'b1; cmd_valid = 1'b0; cmd_type = '0; cmd_len = '0; cmd_data = '0; rsp_ready = 1'b0;
    dr_cap = 64'h0; ir_cap = 5'h05;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    check("rst_rsp", 128'({rsp_valid, rsp_data}), 128'(0));
    check("rst_pins", 128'({tap_sync, tck, tms, tdi}), 128'(4'b0010));
    rst = 1'b0;
    @(negedge clk);

    simple_cmd(T_RESET, 0);

    dr_cap = 64'h3C;
    scan(T_DR, 8, 64'hA5, 0);
    scan(T_IR, 5, 64'h11, 0);
    check("ir_holds_0x11", 128'(ir_upd), 128'(5'h11));

    dr_cap = 64'hDEADBEEF_01234567;
    scan(T_DR, 64, '1, 10);

    scan(T_DR, 0, 64'hFFFF, 2);
    simple_cmd(T_IDLE, 0);
    simple_cmd(T_IDLE, 7);

    dr_cap = {$urandom, $urandom};
    scan(T_DR, 100, {$urandom, $urandom}, 0);

    n_rnd = 12;
    for (int k = 0; k < n_rnd; k++) begin
      t      = ($urandom_range(0, 1) == 0) ? T_DR : T_IR;
      dr_cap = {$urandom, $urandom};
      ir_cap = 5'($urandom);
      scan(t, $urandom_range(1, 64), {$urandom, $urandom}, $urandom_range(0, 3));
    end

    // abort a DR scan while shifting bit 3
    start = rises;
    cmd_valid = 1'b1; cmd_type = T_DR; cmd_len = LW'(16); cmd_data = {$urandom, $urandom};
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (rises - start < 6 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("abort_reach_bit3", 128'(rises - start), 128'(6));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_pins", 128'({tck, tms, cmd_ready, tap_sync, rsp_valid}), 128'(5'b01100));
    simple_cmd(T_RESET, 0);
    dr_cap = 64'h5A;
    scan(T_DR, 8, 64'h0F, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
